player_move_permit: RTL and testbench

//  Movement-permission engine for the player object; the other end of the player's move-enable interface.

---
 rtl/player_move_permit.sv | 196 +++++++++++++++++++
 tb/tb_player_move_permit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/player_move_permit.sv
// Movement-permission engine: scans the obstacle ROM and screen limits
// and registers up/down/left/right move enables for the player object.
//
// Ports:
//   btnClk2, rst           clock, synchronous active-high reset
//   start                  request a scan (honoured in IDLE only)
//   hPos, vPos             player left/top edge
//   objWidth, objHeight    player size
//   obs_addr               obstacle ROM address (1-cycle read latency)
//   obs_hPos, obs_vPos     obstacle left/top edge
//   obs_w, obs_h           obstacle size; obs_w == 0 marks an empty slot
//   upEnable..rightEnable  registered move permits
//   busy                   scan in progress
//   done                   one-cycle pulse when the enables update
module player_move_permit #(
  parameter int NUM_OBS = 8,
  parameter int STEP    = 12,
  parameter int H_MIN   = 0,
  parameter int H_MAX   = 640,
  parameter int V_MIN   = 0,
  parameter int V_MAX   = 480
) (
  input  logic        btnClk2,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] hPos,
  input  logic [11:0] vPos,
  input  logic [11:0] objWidth,
  input  logic [11:0] objHeight,
  output logic [3:0]  obs_addr,
  input  logic [11:0] obs_hPos,
  input  logic [11:0] obs_vPos,
  input  logic [11:0] obs_w,
  input  logic [11:0] obs_h,
  output logic        upEnable,
  output logic        downEnable,
  output logic        leftEnable,
  output logic        rightEnable,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CHK,
    DONE
  } state_t;

  localparam logic [3:0]  LAST_ADDR = 4'(NUM_OBS - 1);
  localparam logic [13:0] STEP14    = 14'(STEP);
  localparam logic [13:0] UP_MIN    = 14'(V_MIN + STEP);
  localparam logic [13:0] LEFT_MIN  = 14'(H_MIN + STEP);
  localparam logic [13:0] DOWN_MAX  = 14'(V_MAX);
  localparam logic [13:0] RIGHT_MAX = 14'(H_MAX);

  state_t state;

  logic [11:0] hLat;
  logic [11:0] vLat;
  logic [11:0] wLat;
  logic [11:0] htLat;

  // bit order everywhere: {up, down, left, right}
  logic [3:0] blocked;
  logic [3:0] hitVec;
  logic [3:0] blkNext;
  logic [3:0] bndOk;

  logic [13:0] pH;
  logic [13:0] pV;
  logic [13:0] pW;
  logic [13:0] pHt;
  logic [13:0] oH;
  logic [13:0] oV;
  logic [13:0] oW;
  logic [13:0] oHt;
  logic [13:0] upV;
  logic [13:0] dnV;
  logic [13:0] lfH;
  logic [13:0] rtH;
  logic        obsUsed;

  // Half-open rectangles: touching edges do not overlap.
  // 14-bit sums so that a shifted candidate plus its size never wraps.
  function automatic logic overlap(
    input logic [13:0] ah,
    input logic [13:0] av,
    input logic [13:0] aw,
    input logic [13:0] aht,
    input logic [13:0] bh,
    input logic [13:0] bv,
    input logic [13:0] bw,
    input logic [13:0] bht
  );
    return (ah < bh + bw) && (bh < ah + aw) &&
           (av < bv + bht) && (bv < av + aht);
  endfunction

  always_comb begin
    pH  = {2'b00, hLat};
    pV  = {2'b00, vLat};
    pW  = {2'b00, wLat};
    pHt = {2'b00, htLat};
    oH  = {2'b00, obs_hPos};
    oV  = {2'b00, obs_vPos};
    oW  = {2'b00, obs_w};
    oHt = {2'b00, obs_h};
    // up/left may underflow near 0; the boundary check blocks
    // those directions, so the wrapped value never matters.
    upV = pV - STEP14;
    dnV = pV + STEP14;
    lfH = pH - STEP14;
    rtH = pH + STEP14;
    obsUsed = (obs_w != 12'd0);
  end

  always_comb begin
    hitVec = 4'b0000;
    if (obsUsed) begin
      hitVec[3] = overlap(pH, upV, pW, pHt, oH, oV, oW, oHt);
      hitVec[2] = overlap(pH, dnV, pW, pHt, oH, oV, oW, oHt);
      hitVec[1] = overlap(lfH, pV, pW, pHt, oH, oV, oW, oHt);
      hitVec[0] = overlap(rtH, pV, pW, pHt, oH, oV, oW, oHt);
    end
    blkNext = blocked | hitVec;
  end

  always_comb begin
    bndOk    = 4'b0000;
    bndOk[3] = (pV >= UP_MIN);
    bndOk[2] = (pV + pHt + STEP14 <= DOWN_MAX);
    bndOk[1] = (pH >= LEFT_MIN);
    bndOk[0] = (pH + pW + STEP14 <= RIGHT_MAX);
  end

  always_ff @(posedge btnClk2) begin
    if (rst) begin
      state       <= IDLE;
      obs_addr    <= 4'd0;
      hLat        <= 12'd0;
      vLat        <= 12'd0;
      wLat        <= 12'd0;
      htLat       <= 12'd0;
      blocked     <= 4'b0000;
      upEnable    <= 1'b0;
      downEnable  <= 1'b0;
      leftEnable  <= 1'b0;
      rightEnable <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            hLat     <= hPos;
            vLat     <= vPos;
            wLat     <= objWidth;
            htLat    <= objHeight;
            blocked  <= 4'b0000;
            obs_addr <= 4'd0;
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          state <= CHK;
        end
        CHK: begin
          blocked <= blkNext;
          if (obs_addr == LAST_ADDR) begin
            upEnable    <= ~blkNext[3] & bndOk[3];
            downEnable  <= ~blkNext[2] & bndOk[2];
            leftEnable  <= ~blkNext[1] & bndOk[1];
            rightEnable <= ~blkNext[0] & bndOk[0];
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            obs_addr <= obs_addr + 4'd1;
            state    <= WAIT;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_move_permit.sv
// Directed bench for player_move_permit.
// Obstacle ROM is modelled as a registered 16-entry table.
module tb_player_move_permit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] hPos;
  logic [11:0] vPos;
  logic [11:0] objWidth;
  logic [11:0] objHeight;
  logic [3:0]  obsAddr;
  logic [11:0] obsH;
  logic [11:0] obsV;
  logic [11:0] obsW;
  logic [11:0] obsHt;
  logic        upEn;
  logic        dnEn;
  logic        lfEn;
  logic        rtEn;
  logic        busy;
  logic        done;

  logic [11:0] tblH  [16];
  logic [11:0] tblV  [16];
  logic [11:0] tblW  [16];
  logic [11:0] tblHt [16];

  int nTests;
  int nFail;

  player_move_permit dut (
    .btnClk2     (clk),
    .rst         (rst),
    .start       (start),
    .hPos        (hPos),
    .vPos        (vPos),
    .objWidth    (objWidth),
    .objHeight   (objHeight),
    .obs_addr    (obsAddr),
    .obs_hPos    (obsH),
    .obs_vPos    (obsV),
    .obs_w       (obsW),
    .obs_h       (obsHt),
    .upEnable    (upEn),
    .downEnable  (dnEn),
    .leftEnable  (lfEn),
    .rightEnable (rtEn),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    obsH  <= tblH[obsAddr];
    obsV  <= tblV[obsAddr];
    obsW  <= tblW[obsAddr];
    obsHt <= tblHt[obsAddr];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearObs();
    for (int i = 0; i < 16; i++) begin
      tblH[i]  = 12'd0;
      tblV[i]  = 12'd0;
      tblW[i]  = 12'd0;
      tblHt[i] = 12'd0;
    end
  endtask

  task automatic setObs(input int i, input int h, input int v);
    tblH[i]  = 12'(h);
    tblV[i]  = 12'(v);
    tblW[i]  = 12'd12;
    tblHt[i] = 12'd12;
  endtask

  task automatic setPlayer(input int h, input int v);
    hPos      = 12'(h);
    vPos      = 12'(v);
    objWidth  = 12'd12;
    objHeight = 12'd12;
  endtask

  function automatic logic [3:0] ens();
    return {upEn, dnEn, lfEn, rtEn};
  endfunction

  // Pulse start at a negedge, count edges (sampling edge = 1)
  // until done is seen; returns to IDLE before exiting.
  task automatic runScan(input string tag, input logic [3:0] expEn,
                         input bit moveMid);
    int n;
    start = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (moveMid) setPlayer(308, 372);
    while (!done && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, "_lat"}, n, 17);
    check({tag, "_en"}, 32'(ens()), 32'(expEn));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    int consec;
    int errDone;
    int errBusy;
    int n;
    logic prevDone;
    nTests = 0;
    nFail  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    clearObs();
    setPlayer(308, 372);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en", 32'(ens()), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(obsAddr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    runScan("empty", 4'b1111, 1'b0);

    setObs(3, 308, 350);
    runScan("obsUp", 4'b0111, 1'b0);
    setObs(3, 308, 348);
    runScan("touchUp", 4'b1111, 1'b0);
    clearObs();
    setObs(3, 320, 372);
    runScan("obsRt", 4'b1110, 1'b0);
    setObs(3, 332, 372);
    runScan("touchRt", 4'b1111, 1'b0);
    clearObs();
    setObs(7, 290, 372);
    runScan("obsLf", 4'b1101, 1'b0);
    clearObs();
    setObs(0, 308, 390);
    runScan("obsDn", 4'b1011, 1'b0);
    clearObs();
    tblH[7] = 12'd310;
    tblV[7] = 12'd360;
    tblW[7] = 12'd0;
    tblHt[7] = 12'd12;
    runScan("zeroW", 4'b1111, 1'b0);
    clearObs();

    setPlayer(5, 470);
    runScan("corner", 4'b1001, 1'b1);

    // start held: done after edges 17 and 35, busy low on 17/18
    pulses   = 0;
    consec   = 0;
    errDone  = 0;
    errBusy  = 0;
    prevDone = 1'b0;
    start    = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) pulses++;
      if (done && prevDone) consec++;
      if (done !== ((k % 18) == 17)) errDone++;
      if (busy !== !((k % 18) == 17 || (k % 18) == 0)) errBusy++;
      prevDone = done;
    end
    start = 1'b0;
    check("hold_pulses", pulses, 2);
    check("hold_consec", consec, 0);
    check("hold_doneAt", errDone, 0);
    check("hold_busy", errBusy, 0);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("hold_drain", 32'(done), 32'd1);
    check("hold_en", 32'(ens()), 32'hf);
    @(posedge clk);
    @(negedge clk);

    // abort during CHK of obstacle 4
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (obsAddr != 4'd4 && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("abort_reach", 32'(obsAddr), 32'd4);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_en", 32'(ens()), 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_addr", 32'(obsAddr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    runScan("recover", 4'b1111, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
